// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for two byte requesters feeding one strobe-timed UART transmitter.
// Frame: one start bit, eight data bits LSB first, STOP_BITS stop bits.
module uart_tx_arbiter #(
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       Txclk_en,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       grant_id,
   output logic       frame_done
);
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;

   state_t               state, state_d;
   logic [DATA_W-1:0]    shift, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
   logic                 stop_cnt, stop_cnt_d;
   logic                 last, last_d;
   logic                 tx_d, grant_d, done_d;
   logic                 sel, accept;

   // A lone valid wins outright; a tie goes to the requester not served last.
   always_comb begin
      sel = 1'b0;
      if (req0_valid && req1_valid) begin
         sel = ~last;
      end else if (req1_valid) begin
         sel = 1'b1;
      end
   end

   assign req0_ready = (state == IDLE) & ~rst & req0_valid & ~sel;
   assign req1_ready = (state == IDLE) & ~rst & req1_valid & sel;
   assign accept     = req0_ready | req1_ready;

   always_comb begin
      state_d    = state;
      shift_d    = shift;
      bit_cnt_d  = bit_cnt;
      stop_cnt_d = stop_cnt;
      last_d     = last;
      tx_d       = tx;
      grant_d    = grant_id;
      done_d     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               shift_d = sel ? req1_data : req0_data;
               grant_d = sel;
               last_d  = sel;
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (Txclk_en) begin
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (Txclk_en) begin
               tx_d      = shift[0];
               shift_d   = {1'b0, shift[DATA_W-1:1]};
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (Txclk_en) begin
               if (bit_cnt == LAST_BIT) begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = STOP;
               end else begin
                  tx_d      = shift[0];
                  shift_d   = {1'b0, shift[DATA_W-1:1]};
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end
         STOP: begin
            if (Txclk_en) begin
               if (stop_cnt == LAST_STOP) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = stop_cnt + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset abandons any frame in flight; last=1 lets requester 0 win the first tie.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         last       <= 1'b1;
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
         grant_id   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         shift      <= shift_d;
         bit_cnt    <= bit_cnt_d;
         stop_cnt   <= stop_cnt_d;
         last       <= last_d;
         tx         <= tx_d;
         tx_busy    <= (state_d != IDLE);
         grant_id   <= grant_d;
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (1 and 2 stop bits) share stimulus; each
// cycle is logged and replayed through a strobe-counting model of the frame rules.
module tb_uart_tx_arbiter;
   localparam int MAXC = 4096;

   logic       clk_50m = 1'b0;
   logic       rst, Txclk_en;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       r0_a, r1_a, tx_a, busy_a, gid_a, done_a;
   logic       r0_b, r1_b, tx_b, busy_b, gid_b, done_b;

   int n_checks, n_pass, ncyc, div, div_cnt;

   logic       lg_v0 [MAXC];
   logic       lg_v1 [MAXC];
   logic       lg_st [MAXC];
   logic [7:0] lg_d0 [MAXC];
   logic [7:0] lg_d1 [MAXC];
   logic       lg_r0 [2][MAXC];
   logic       lg_r1 [2][MAXC];
   logic       lg_tx [2][MAXC];
   logic       lg_busy [2][MAXC];
   logic       lg_done [2][MAXC];
   logic       lg_gid [2][MAXC];

   always #10 clk_50m = ~clk_50m;

   uart_tx_arbiter #(.STOP_BITS(1)) dut_a (
      .clk_50m(clk_50m), .rst(rst), .Txclk_en(Txclk_en),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_a),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_a),
      .tx(tx_a), .tx_busy(busy_a), .grant_id(gid_a), .frame_done(done_a));

   uart_tx_arbiter #(.STOP_BITS(2)) dut_b (
      .clk_50m(clk_50m), .rst(rst), .Txclk_en(Txclk_en),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_b),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_b),
      .tx(tx_b), .tx_busy(busy_b), .grant_id(gid_b), .frame_done(done_b));

   // One clock: log inputs/readies seen by the edge, then outputs after it, then next strobe.
   task automatic tick();
      if (ncyc < MAXC) begin
         lg_v0[ncyc] = req0_valid; lg_v1[ncyc] = req1_valid;
         lg_d0[ncyc] = req0_data;  lg_d1[ncyc] = req1_data;
         lg_st[ncyc] = Txclk_en;
         lg_r0[0][ncyc] = r0_a; lg_r1[0][ncyc] = r1_a;
         lg_r0[1][ncyc] = r0_b; lg_r1[1][ncyc] = r1_b;
      end
      @(negedge clk_50m);
      if (ncyc < MAXC) begin
         lg_tx[0][ncyc] = tx_a; lg_busy[0][ncyc] = busy_a; lg_done[0][ncyc] = done_a; lg_gid[0][ncyc] = gid_a;
         lg_tx[1][ncyc] = tx_b; lg_busy[1][ncyc] = busy_b; lg_done[1][ncyc] = done_b; lg_gid[1][ncyc] = gid_b;
         ncyc++;
      end
      div_cnt = div_cnt + 1;
      if (div_cnt >= div) begin
         div_cnt  = 0;
         Txclk_en = 1'b1;
      end else begin
         Txclk_en = 1'b0;
      end
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      rst = 1'b0; ncyc = 0; #1;
   endtask

   // Raise one valid, hold it until the chosen instance accepts, then drop all valids.
   task automatic send_one(input int d, input int id, input logic [7:0] data, output bit ok);
      int guard = 0;
      if (id == 0) begin req0_valid = 1'b1; req0_data = data; end
      else begin req1_valid = 1'b1; req1_data = data; end
      #1;
      while (!((d == 0) ? ((id == 0) ? r0_a : r1_a) : ((id == 0) ? r0_b : r1_b)) && guard < 2000) begin
         tick(); guard++;
      end
      ok = (guard < 2000);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0; #1;
   endtask

   task automatic wait_idle(output bit ok);
      int guard = 0;
      while ((busy_a || busy_b) && guard < 3000) begin tick(); guard++; end
      ok = (guard < 3000);
      tick();
   endtask

   function automatic int kth_xfer(input int d, input int k);
      int n = 0;
      for (int j = 0; j < ncyc; j++)
         if ((lg_v0[j] && lg_r0[d][j]) || (lg_v1[j] && lg_r1[d][j])) begin
            if (n == k) return j;
            n++;
         end
      return -1;
   endfunction

   function automatic int nth_strobe_after(input int c, input int n);
      int k = 0;
      for (int j = c + 1; j < ncyc; j++)
         if (j >= 0 && lg_st[j]) begin
            k++;
            if (k == n) return j;
         end
      return -1;
   endfunction

   function automatic int count_done(input int d);
      int n = 0;
      for (int j = 0; j < ncyc; j++) if (lg_done[d][j]) n++;
      return n;
   endfunction

   function automatic int count_both_ready(input int d);
      int n = 0;
      for (int j = 0; j < ncyc; j++) if (lg_r0[d][j] && lg_r1[d][j]) n++;
      return n;
   endfunction

   // Reference: after a grant, tx is a function of how many strobes have followed it:
   // 0 -> idle high, 1 -> start, 2..9 -> data bits, >=10 -> stop; frame ends at 10+sb.
   task automatic run_model(input int d, input int sb, output int m_rdy, output int m_tx,
                            output int m_busy, output int m_done, output int m_gid);
      logic       busy, last, grant, sel, tx_e, done_e;
      logic [7:0] data;
      int         n;
      busy = 1'b0; last = 1'b1; grant = 1'b0; data = '0; n = 0;
      m_rdy = 0; m_tx = 0; m_busy = 0; m_done = 0; m_gid = 0;
      for (int j = 0; j < ncyc; j++) begin
         sel = (lg_v0[j] && lg_v1[j]) ? ~last : lg_v1[j];
         if (lg_r0[d][j] !== (!busy && lg_v0[j] && !sel) || lg_r1[d][j] !== (!busy && lg_v1[j] && sel))
            m_rdy++;
         done_e = 1'b0;
         if (!busy && (lg_v0[j] || lg_v1[j])) begin
            busy = 1'b1; n = 0; data = sel ? lg_d1[j] : lg_d0[j]; grant = sel; last = sel;
         end else if (busy && lg_st[j]) begin
            n++;
            if (n == 10 + sb) begin busy = 1'b0; done_e = 1'b1; end
         end
         if (!busy || n == 0 || n >= 10) tx_e = 1'b1;
         else if (n == 1) tx_e = 1'b0;
         else tx_e = data[n-2];
         if (lg_tx[d][j] !== tx_e) m_tx++;
         if (lg_busy[d][j] !== busy) m_busy++;
         if (lg_done[d][j] !== done_e) m_done++;
         if (lg_gid[d][j] !== grant) m_gid++;
      end
   endtask

   task automatic test_reset();
      bit ok1, ok2, ok3; int c, guard, mr, mt, mb, md, mg;
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h5A; req1_data = 8'hC3; #1;
      n_checks++; if ({r0_a, r1_a, r0_b, r1_b} !== 4'b0000) $display("FAIL reset_ready got %b required 0000", {r0_a, r1_a, r0_b, r1_b}); else n_pass++;
      tick();
      n_checks++; if ({tx_a, busy_a, gid_a, done_a} !== 4'b1000) $display("FAIL reset_out_a tx/busy/gid/done got %b required 1000", {tx_a, busy_a, gid_a, done_a}); else n_pass++;
      n_checks++; if ({tx_b, busy_b, gid_b, done_b} !== 4'b1000) $display("FAIL reset_out_b tx/busy/gid/done got %b required 1000", {tx_b, busy_b, gid_b, done_b}); else n_pass++;
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; ncyc = 0; div = 4; div_cnt = 0; #1;
      send_one(0, 1, 8'hA5, ok1);
      c = kth_xfer(0, 0); guard = 0;
      while (nth_strobe_after(c, 5) < 0 && guard < 200) begin tick(); guard++; end
      ok2 = (guard < 200);
      n_checks++; if ({ok1, ok2, tx_a, gid_a} !== 4'b1101) $display("FAIL mid_data_state ok/ok/tx/gid got %b required 1101", {ok1, ok2, tx_a, gid_a}); else n_pass++;
      rst = 1'b1; req0_valid = 1'b1; #1;
      n_checks++; if ({r0_a, r1_a} !== 2'b00) $display("FAIL mid_reset_ready got %b required 00", {r0_a, r1_a}); else n_pass++;
      tick();
      n_checks++; if ({tx_a, busy_a, gid_a, done_a} !== 4'b1000) $display("FAIL mid_reset_out tx/busy/gid/done got %b required 1000", {tx_a, busy_a, gid_a, done_a}); else n_pass++;
      rst = 1'b0; req0_valid = 1'b0; ncyc = 0; #1;
      send_one(0, 0, 8'h3C, ok1);
      wait_idle(ok3);
      n_checks++; if ({ok1, ok3} !== 2'b11) $display("FAIL after_reset_timeout got %b required 11", {ok1, ok3}); else n_pass++;
      run_model(0, 1, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL after_reset_model_sb1 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
      run_model(1, 2, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL after_reset_model_sb2 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   task automatic test_frame_a5();
      bit ok1, ok2; int c, s, cnt, mr, mt, mb, md, mg; logic [9:0] seq;
      apply_reset(); div = 4; div_cnt = 0;
      send_one(0, 0, 8'hA5, ok1);
      wait_idle(ok2);
      n_checks++; if ({ok1, ok2} !== 2'b11) $display("FAIL a5_timeout got %b required 11", {ok1, ok2}); else n_pass++;
      c = kth_xfer(0, 0);
      for (int i = 0; i < 10; i++) begin
         s = nth_strobe_after(c, i + 1);
         seq[i] = (c >= 0 && s >= 0) ? lg_tx[0][s] : 1'bx;
      end
      n_checks++; if (seq !== 10'h34A) $display("FAIL a5_tx_seq (bit0 first strobe) got %b required %b", seq, 10'h34A); else n_pass++;
      cnt = count_done(0);
      n_checks++; if (cnt != 1) $display("FAIL a5_done_count got %0d required 1", cnt); else n_pass++;
      s = nth_strobe_after(c, 1); if (c < 0 || s < 0) s = ncyc;
      cnt = 0; for (int j = s; j < ncyc; j++) if (lg_busy[0][j]) cnt++;
      n_checks++; if (cnt != 10 * div) $display("FAIL a5_busy_cycles got %0d required %0d", cnt, 10 * div); else n_pass++;
      run_model(0, 1, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL a5_model_sb1 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit ok; int frames, guard, j0, j1, j2, g0, g1, g2, cnt, mr, mt, mb, md, mg;
      apply_reset(); div = 4;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22; #1;
      frames = 0; guard = 0;
      while (frames < 3 && guard < 2000) begin tick(); guard++; if (done_a) frames++; end
      req0_valid = 1'b0; req1_valid = 1'b0; #1;
      wait_idle(ok);
      n_checks++; if (frames != 3 || !ok) $display("FAIL rr_frames got %0d ok=%0d required 3 ok=1", frames, ok); else n_pass++;
      j0 = kth_xfer(0, 0); j1 = kth_xfer(0, 1); j2 = kth_xfer(0, 2);
      g0 = (j0 >= 0) ? int'(lg_r1[0][j0]) : 9; g1 = (j1 >= 0) ? int'(lg_r1[0][j1]) : 9; g2 = (j2 >= 0) ? int'(lg_r1[0][j2]) : 9;
      n_checks++; if (g0 != 0 || g1 != 1 || g2 != 0 || kth_xfer(0, 3) != -1) $display("FAIL rr_order got %0d,%0d,%0d required 0,1,0 and no fourth", g0, g1, g2); else n_pass++;
      cnt = count_done(0);
      n_checks++; if (cnt != 3) $display("FAIL rr_done_count got %0d required 3", cnt); else n_pass++;
      cnt = count_both_ready(0) + count_both_ready(1);
      n_checks++; if (cnt != 0) $display("FAIL rr_both_ready cycles got %0d required 0", cnt); else n_pass++;
      run_model(0, 1, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL rr_model_sb1 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
      run_model(1, 2, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL rr_model_sb2 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   task automatic test_single_requester();
      bit ok, took; int frames, guard, j0, j1, d0, cnt, mr, mt, mb, md, mg;
      apply_reset(); div = 4;
      req1_valid = 1'b1; req1_data = 8'h55; #1;
      frames = 0; guard = 0;
      while (frames < 2 && guard < 2000) begin
         took = r1_a;
         tick(); guard++;
         if (took) req1_data = 8'hAA;
         if (done_a) frames++;
      end
      req1_valid = 1'b0; #1;
      wait_idle(ok);
      j0 = kth_xfer(0, 0); j1 = kth_xfer(0, 1);
      n_checks++; if (j0 < 0 || j1 < 0 || !lg_r1[0][j0] || !lg_r1[0][j1]) $display("FAIL single_grants idx %0d,%0d required two grants to 1", j0, j1); else n_pass++;
      d0 = -1; for (int j = 0; j < ncyc; j++) if (lg_done[0][j] && d0 < 0) d0 = j;
      n_checks++; if (j1 != d0 + 1) $display("FAIL single_back_to_back second grant at %0d required %0d", j1, d0 + 1); else n_pass++;
      cnt = 0; for (int j = (j0 < 0 ? ncyc : j0); j < ncyc; j++) if (lg_gid[0][j] !== 1'b1) cnt++;
      n_checks++; if (cnt != 0) $display("FAIL single_gid cycles with gid!=1 got %0d required 0", cnt); else n_pass++;
      run_model(0, 1, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL single_model_sb1 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   task automatic test_stop_bits2();
      bit ok1, ok2; int c, lo, hi, dn, s12, mr, mt, mb, md, mg;
      apply_reset(); div = $urandom_range(3, 7); div_cnt = 0;
      send_one(1, 0, 8'hFF, ok1);
      wait_idle(ok2);
      c = kth_xfer(1, 0);
      lo = -1; for (int j = 0; j < ncyc; j++) if (lg_tx[1][j] === 1'b0) begin if (lo < 0) lo = j; end
      n_checks++; if (!ok1 || !ok2 || c < 0 || lo < 0) $display("FAIL stop2_setup ok=%0d%0d xfer=%0d low=%0d required ok=11 and both found", ok1, ok2, c, lo); else n_pass++;
      if (lo < 0) lo = ncyc;
      hi = 0; for (int j = lo + 1; j < ncyc; j++) if (lg_busy[1][j] && lg_tx[1][j]) hi++;
      n_checks++; if (hi != 10 * div) $display("FAIL stop2_high_cycles got %0d required %0d", hi, 10 * div); else n_pass++;
      hi = 0; for (int j = 0; j < ncyc; j++) if (lg_tx[1][j] === 1'b0) hi++;
      n_checks++; if (hi != div) $display("FAIL stop2_low_cycles got %0d required %0d", hi, div); else n_pass++;
      dn = -1; for (int j = 0; j < ncyc; j++) if (lg_done[1][j] && dn < 0) dn = j;
      s12 = nth_strobe_after(c, 12);
      n_checks++; if (dn < 0 || dn != s12) $display("FAIL stop2_done_at got %0d required %0d", dn, s12); else n_pass++;
      run_model(1, 2, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL stop2_model_sb2 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   task automatic test_coincident();
      bit ok1, ok2; int guard, early, c, lo, j1, mr, mt, mb, md, mg;
      apply_reset(); div = 4;
      guard = 0;
      while (Txclk_en !== 1'b1 && guard < 20) begin tick(); guard++; end
      req0_valid = 1'b1; req0_data = 8'($urandom); #1;
      n_checks++; if ({Txclk_en, r0_a} !== 2'b11) $display("FAIL coinc_setup strobe/ready got %b required 11", {Txclk_en, r0_a}); else n_pass++;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'($urandom); #1;
      early = 0; guard = 0;
      while (busy_a && guard < 1000) begin if (r1_a) early++; tick(); guard++; end
      ok1 = (guard < 1000);
      n_checks++; if (early != 0 || !ok1) $display("FAIL coinc_ready_during_frame got %0d ok=%0d required 0 ok=1", early, ok1); else n_pass++;
      guard = 0;
      while (!r1_a && guard < 100) begin tick(); guard++; end
      tick();
      req1_valid = 1'b0; #1;
      wait_idle(ok2);
      c = kth_xfer(0, 0);
      lo = -1; for (int j = c + 1; j < ncyc; j++) if (j >= 0 && lg_tx[0][j] === 1'b0 && lo < 0) lo = j;
      n_checks++; if (c < 0 || lo - c != div) $display("FAIL coinc_start_latency got %0d cycles required %0d", lo - c, div); else n_pass++;
      j1 = kth_xfer(0, 1);
      n_checks++; if (c < 0 || j1 < 0 || lg_r1[0][c] !== 1'b0 || lg_r1[0][j1] !== 1'b1 || !ok2) $display("FAIL coinc_order idx %0d,%0d required grants 0 then 1", c, j1); else n_pass++;
      run_model(0, 1, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL coinc_model_sb1 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
      run_model(1, 2, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL coinc_model_sb2 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   task automatic test_random();
      int cnt, mr, mt, mb, md, mg;
      apply_reset(); div = $urandom_range(2, 6); div_cnt = 0;
      for (int i = 0; i < 1500; i++) begin
         req0_valid = ($urandom_range(0, 99) < 55);
         req1_valid = ($urandom_range(0, 99) < 55);
         req0_data  = 8'($urandom);
         req1_data  = 8'($urandom);
         #1;
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; #1;
      cnt = count_done(0);
      n_checks++; if (cnt < 3) $display("FAIL rand_frames got %0d required at least 3", cnt); else n_pass++;
      cnt = count_both_ready(0) + count_both_ready(1);
      n_checks++; if (cnt != 0) $display("FAIL rand_both_ready cycles got %0d required 0", cnt); else n_pass++;
      run_model(0, 1, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL rand_model_sb1 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
      run_model(1, 2, mr, mt, mb, md, mg);
      n_checks++; if (mr + mt + mb + md + mg != 0) $display("FAIL rand_model_sb2 ready=%0d tx=%0d busy=%0d done=%0d gid=%0d required 0", mr, mt, mb, md, mg); else n_pass++;
   endtask

   initial begin
      n_checks = 0; n_pass = 0; ncyc = 0; div = 4; div_cnt = 0;
      rst = 1'b1; Txclk_en = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
      test_reset();
      test_frame_a5();
      test_round_robin();
      test_single_requester();
      test_stop_bits2();
      test_coincident();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
